// File: rtl/dcmac_0_axis_pkt_gen_pkg.sv
// dcmac_0_axis_pkt_gen_pkg: shared segment-bus types and limits for the packet generator
package dcmac_0_axis_pkt_gen_pkg;
  localparam int NUM_SEG = 12;
  localparam int SEG_BYTES = 16;
  localparam int MAX_EOP = 3;
  localparam int LEN_W = 16;
  localparam logic [LEN_W-1:0] MIN_LEN = 16'd64;
  localparam logic [LEN_W-1:0] MAX_LEN = 16'd9600;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;
  typedef struct packed {
    logic [2:0] id;
    logic [NUM_SEG-1:0] ena;
    logic [NUM_SEG-1:0] sop;
    logic [NUM_SEG-1:0] eop;
    logic [NUM_SEG-1:0] err;
    logic [NUM_SEG-1:0][3:0] mty;
    logic [NUM_SEG-1:0][LEN_W-1:0] pkt_len;
    logic [MAX_EOP-1:0][3:0] pkt_mty_idx;
    logic [MAX_EOP-1:0][5:0] mty_sum;
  } lbus_pkt_ctrl_t;
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return l < MIN_LEN ? MIN_LEN : l > MAX_LEN ? MAX_LEN : l;
  endfunction
endpackage

// File: rtl/dcmac_0_axis_pkt_gen_len_gen.sv
// dcmac_0_axis_pkt_gen_len_gen: three lookahead packet lengths with clamp, sweep wrap and advance-by-n
module dcmac_0_axis_pkt_gen_len_gen
  import dcmac_0_axis_pkt_gen_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_i,
  input  logic                          incr_i,
  input  logic [LEN_W-1:0]              min_i,
  input  logic [LEN_W-1:0]              max_i,
  input  logic [1:0]                    adv_i,
  output logic [MAX_EOP-1:0][LEN_W-1:0] len_o
);
  logic [LEN_W-1:0] cur_q, cur_d, min_q, max_q, min_c, max_c, len3;
  logic incr_q;
  function automatic logic [LEN_W-1:0] nxt(input logic [LEN_W-1:0] l, input logic [LEN_W-1:0] mn,
                                           input logic [LEN_W-1:0] mx, input logic inc);
    return (inc && l != mx) ? l + 1'b1 : mn;
  endfunction
  assign min_c = clamp_len(min_i);
  assign max_c = clamp_len(max_i);
  always_comb begin
    len_o[0] = cur_q;
    len_o[1] = nxt(cur_q, min_q, max_q, incr_q);
    len_o[2] = nxt(len_o[1], min_q, max_q, incr_q);
    len3 = nxt(len_o[2], min_q, max_q, incr_q);
    cur_d = adv_i == 2'd0 ? cur_q : adv_i == 2'd1 ? len_o[1] : adv_i == 2'd2 ? len_o[2] : len3;
  end
  // An inverted range degenerates to a fixed length at the clamped minimum.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q <= '0;
      min_q <= '0;
      max_q <= '0;
      incr_q <= 1'b0;
    end else if (load_i) begin
      cur_q <= min_c;
      min_q <= min_c;
      max_q <= max_c;
      incr_q <= incr_i && min_c <= max_c;
    end else begin
      cur_q <= cur_d;
    end
  end
endmodule

// File: rtl/dcmac_0_axis_pkt_gen_seg_sched.sv
// dcmac_0_axis_pkt_gen_seg_sched: packs generated packets onto the 12x16B segment bus
module dcmac_0_axis_pkt_gen_seg_sched
  import dcmac_0_axis_pkt_gen_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic           i_stop,
  input  logic [2:0]     i_cfg_id,
  input  logic [15:0]    i_cfg_len_min,
  input  logic [15:0]    i_cfg_len_max,
  input  logic           i_cfg_incr,
  input  logic [31:0]    i_cfg_pkt_cnt,
  input  logic           i_err_inj,
  input  logic           i_rdy,
  output logic           o_vld,
  output lbus_pkt_ctrl_t o_pkt_ctrl,
  output logic           o_busy,
  output logic           o_done,
  output logic [31:0]    o_pkt_sent
);
  state_e state_q, state_d;
  lbus_pkt_ctrl_t ctrl_q, beat;
  logic [2:0] id_q;
  logic [31:0] cnt_q, started_q, sent_q;
  logic [LEN_W-1:0] rem_q, cur_len_q, rem, len;
  logic [MAX_EOP-1:0][LEN_W-1:0] la;
  logic [1:0] nsop, neop, neop_q;
  logic [5:0] sum;
  logic [32:0] sent_sum;
  logic vld_q, done_q, stop_q, err_q, halt, err_left;
  logic stop_pend, err_pend, acc, fin, load, start_ok, busy;

  dcmac_0_axis_pkt_gen_len_gen u_len_gen (
    .clk    (clk),
    .rst    (rst),
    .load_i (start_ok),
    .incr_i (i_cfg_incr),
    .min_i  (i_cfg_len_min),
    .max_i  (i_cfg_len_max),
    .adv_i  (load ? nsop : 2'd0),
    .len_o  (la)
  );

  assign busy = state_q == LOAD || state_q == RUN;
  assign start_ok = i_start && !busy;
  assign stop_pend = stop_q || i_stop;
  assign err_pend = err_q || i_err_inj;
  assign acc = vld_q && i_rdy;
  // The run ends only on a beat boundary with no packet left open.
  assign fin = state_q == RUN && acc && rem_q == '0 && (stop_pend || (cnt_q != '0 && started_q >= cnt_q));
  assign load = state_q == LOAD || (state_q == RUN && acc && !fin);
  assign sent_sum = {1'b0, sent_q} + 33'(neop_q);

  always_comb begin
    state_d = start_ok ? LOAD : state_q == LOAD ? RUN : fin ? DONE : state_q;
  end

  always_comb begin
    beat = '0;
    beat.id = id_q;
    beat.pkt_mty_idx = {MAX_EOP{4'd12}};
    rem = rem_q;
    len = cur_len_q;
    nsop = '0;
    neop = '0;
    sum = '0;
    halt = 1'b0;
    err_left = err_pend;
    for (int i = 0; i < NUM_SEG; i++) begin
      if (rem == '0 && !halt) begin
        if (!stop_pend && nsop != 2'd3 && (cnt_q == '0 || started_q + 32'(nsop) < cnt_q)) begin
          len = la[nsop];
          rem = len;
          beat.sop[i] = 1'b1;
          nsop = nsop + 2'd1;
        end else begin
          halt = 1'b1;
        end
      end
      if (!halt) begin
        beat.ena[i] = 1'b1;
        beat.pkt_len[i] = len;
        if (rem <= LEN_W'(SEG_BYTES)) begin
          beat.eop[i] = 1'b1;
          beat.err[i] = err_left;
          err_left = 1'b0;
          beat.mty[i] = 4'(LEN_W'(SEG_BYTES) - rem);
          sum = sum + 6'(beat.mty[i]);
          beat.pkt_mty_idx[neop] = 4'(i + 1);
          beat.mty_sum[neop] = sum;
          neop = neop + 2'd1;
          rem = '0;
        end else begin
          rem = rem - LEN_W'(SEG_BYTES);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ctrl_q <= '0;
      id_q <= '0;
      cnt_q <= '0;
      started_q <= '0;
      sent_q <= '0;
      rem_q <= '0;
      cur_len_q <= '0;
      neop_q <= '0;
      vld_q <= 1'b0;
      done_q <= 1'b0;
      stop_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q <= fin;
      stop_q <= busy && stop_pend && !fin;
      err_q <= busy && err_pend;
      if (start_ok) begin
        id_q <= i_cfg_id;
        cnt_q <= i_cfg_pkt_cnt;
        started_q <= '0;
        sent_q <= '0;
        rem_q <= '0;
        cur_len_q <= '0;
      end
      if (acc) sent_q <= sent_sum[32] ? '1 : sent_sum[31:0];
      if (fin) vld_q <= 1'b0;
      if (load) begin
        vld_q <= 1'b1;
        ctrl_q <= beat;
        neop_q <= neop;
        rem_q <= rem;
        cur_len_q <= len;
        started_q <= started_q + 32'(nsop);
        err_q <= err_left;
      end
    end
  end

  assign o_vld = vld_q;
  assign o_pkt_ctrl = ctrl_q;
  assign o_busy = busy;
  assign o_done = done_q;
  assign o_pkt_sent = sent_q;
endmodule

// File: tb/tb_dcmac_0_axis_pkt_gen_seg_sched.sv
// tb_dcmac_0_axis_pkt_gen_seg_sched: segment-stream model plus directed runs for the segment scheduler
module tb_dcmac_0_axis_pkt_gen_seg_sched;
  import dcmac_0_axis_pkt_gen_pkg::*;
  logic clk = 1'b0, rst = 1'b1, i_start = 1'b0, i_stop = 1'b0, i_cfg_incr = 1'b0, i_err_inj = 1'b0, i_rdy = 1'b1;
  logic [2:0] i_cfg_id = '0;
  logic [15:0] i_cfg_len_min = 16'd64, i_cfg_len_max = 16'd64;
  logic [31:0] i_cfg_pkt_cnt = '0;
  logic o_vld, o_busy, o_done;
  lbus_pkt_ctrl_t o_pkt_ctrl, e, prev, last_acc;
  logic [31:0] o_pkt_sent;
  int tests = 0, fails = 0;
  localparam int NS = 4096;
  bit s_sop[NS], s_eop[NS], s_err[NS];
  int s_len[NS];
  int nseg = 0, ptr = 0, sent_m = 0;
  logic [2:0] cur_id = '0;
  bit hold_q = 1'b0;

  always #5 clk = ~clk;

  dcmac_0_axis_pkt_gen_seg_sched dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop), .i_cfg_id(i_cfg_id),
    .i_cfg_len_min(i_cfg_len_min), .i_cfg_len_max(i_cfg_len_max), .i_cfg_incr(i_cfg_incr),
    .i_cfg_pkt_cnt(i_cfg_pkt_cnt), .i_err_inj(i_err_inj), .i_rdy(i_rdy), .o_vld(o_vld),
    .o_pkt_ctrl(o_pkt_ctrl), .o_busy(o_busy), .o_done(o_done), .o_pkt_sent(o_pkt_sent)
  );

  // Packets laid end to end as a flat stream of 16B segments; each beat is the next 12 of them.
  task automatic gen(int mn, int mx, bit inc, int npk);
    int l, ns;
    mn = mn < 64 ? 64 : mn > 9600 ? 9600 : mn;
    mx = mx < 64 ? 64 : mx > 9600 ? 9600 : mx;
    if (mn > mx) inc = 1'b0;
    l = mn;
    nseg = 0;
    for (int p = 0; p < npk; p++) begin
      ns = (l + 15) / 16;
      for (int s = 0; s < ns; s++) begin
        s_sop[nseg] = s == 0;
        s_eop[nseg] = s == ns - 1;
        s_len[nseg] = l;
        s_err[nseg] = 1'b0;
        nseg++;
      end
      l = (inc && l != mx) ? l + 1 : mn;
    end
  endtask

  function automatic lbus_pkt_ctrl_t exp_beat(int p);
    lbus_pkt_ctrl_t x;
    int k, sm, m;
    x = '0;
    k = 0;
    sm = 0;
    x.id = cur_id;
    x.pkt_mty_idx = {4'd12, 4'd12, 4'd12};
    for (int i = 0; i < 12; i++) begin
      if (p + i < nseg) begin
        x.ena[i] = 1'b1;
        x.sop[i] = s_sop[p + i];
        x.pkt_len[i] = 16'(s_len[p + i]);
        if (s_eop[p + i] && k < 3) begin
          m = (16 - s_len[p + i] % 16) % 16;
          sm += m;
          x.eop[i] = 1'b1;
          x.err[i] = s_err[p + i];
          x.mty[i] = 4'(m);
          x.pkt_mty_idx[k] = 4'(i + 1);
          x.mty_sum[k] = 6'(sm);
          k++;
        end
      end
    end
    return x;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        tests++;
        if (o_pkt_ctrl !== prev) begin
          fails++;
          $display("FAIL hold: got %h exp %h", o_pkt_ctrl, prev);
        end
      end
      if (o_vld) begin
        tests++;
        if (o_pkt_sent !== 32'(sent_m)) begin
          fails++;
          $display("FAIL pkt_sent: got %0d exp %0d", o_pkt_sent, sent_m);
        end
      end
      if (o_vld && i_rdy) begin
        e = exp_beat(ptr);
        tests++;
        if (o_pkt_ctrl !== e) begin
          fails++;
          $display("FAIL beat@%0d: got %h exp %h", ptr, o_pkt_ctrl, e);
        end
        for (int i = 0; i < 12; i++) sent_m += int'(e.eop[i]);
        last_acc = o_pkt_ctrl;
        ptr += 12;
      end
      hold_q = o_vld && !i_rdy;
      prev = o_pkt_ctrl;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d exp %0d", nm, act, exp);
    end
  endtask

  task automatic start_run(logic [2:0] id, int mn, int mx, bit inc, int cnt, int npk);
    gen(mn, mx, inc, npk);
    ptr = 0;
    sent_m = 0;
    cur_id = id;
    i_cfg_id = id;
    i_cfg_len_min = 16'(mn);
    i_cfg_len_max = 16'(mx);
    i_cfg_incr = inc;
    i_cfg_pkt_cnt = 32'(cnt);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic inj_err();
    for (int j = ptr + 12; j < nseg; j++) begin
      if (s_eop[j]) begin
        s_err[j] = 1'b1;
        break;
      end
    end
    i_err_inj = 1'b1;
    step();
    i_err_inj = 1'b0;
  endtask

  task automatic wait_done(string nm, int exp_sent);
    int n;
    n = 0;
    while (!o_done && n < 200) begin
      step();
      n++;
    end
    chk({nm, " done"}, o_done, 1);
    chk({nm, " vld"}, o_vld, 0);
    chk({nm, " sent"}, o_pkt_sent, exp_sent);
    chk({nm, " beats"}, ptr, ((nseg + 11) / 12) * 12);
    step();
    chk({nm, " done pulse"}, o_done, 0);
    chk({nm, " busy"}, o_busy, 0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset vld", o_vld, 0);
    chk("reset busy", o_busy, 0);
    chk("reset done", o_done, 0);
    chk("reset sent", o_pkt_sent, 0);
    chk("reset ctrl", o_pkt_ctrl == '0, 1);
    rst = 1'b0;
    step();
    // fixed 64B continuous, then reset mid-run
    start_run(3'd1, 64, 64, 1'b0, 0, 40);
    chk("t1 latency vld", o_vld, 0);
    chk("t1 latency busy", o_busy, 1);
    step();
    chk("t1 vld", o_vld, 1);
    chk("t1 ena", o_pkt_ctrl.ena, 12'hFFF);
    chk("t1 sop", o_pkt_ctrl.sop, 12'h111);
    chk("t1 eop", o_pkt_ctrl.eop, 12'h888);
    chk("t1 idx", o_pkt_ctrl.pkt_mty_idx, {4'd12, 4'd8, 4'd4});
    chk("t1 sum", o_pkt_ctrl.mty_sum, 0);
    repeat (4) step();
    rst = 1'b1;
    step();
    chk("t1 rst vld", o_vld, 0);
    chk("t1 rst ctrl", o_pkt_ctrl == '0, 1);
    chk("t1 rst busy", o_busy, 0);
    chk("t1 rst sent", o_pkt_sent, 0);
    rst = 1'b0;
    step();
    // fixed 65B with error injection
    start_run(3'd2, 65, 65, 1'b0, 0, 40);
    step();
    chk("t2 eop1", o_pkt_ctrl.eop, 12'h210);
    chk("t2 mty4", o_pkt_ctrl.mty[4], 15);
    chk("t2 mty9", o_pkt_ctrl.mty[9], 15);
    chk("t2 idx1", o_pkt_ctrl.pkt_mty_idx, {4'd12, 4'd10, 4'd5});
    chk("t2 sum1", o_pkt_ctrl.mty_sum, {6'd0, 6'd30, 6'd15});
    step();
    chk("t2 eop2", o_pkt_ctrl.eop, 12'h084);
    chk("t2 idx2", o_pkt_ctrl.pkt_mty_idx[0], 3);
    inj_err();
    chk("t2 err", o_pkt_ctrl.err, 12'h001);
    repeat (3) step();
    reset_dut();
    // packet count 4
    start_run(3'd3, 64, 64, 1'b0, 4, 4);
    step();
    chk("t3 ena1", o_pkt_ctrl.ena, 12'hFFF);
    step();
    chk("t3 ena2", o_pkt_ctrl.ena, 12'h00F);
    chk("t3 eop2", o_pkt_ctrl.eop, 12'h008);
    wait_done("t3", 4);
    // length sweep 64..66
    start_run(3'd4, 64, 66, 1'b1, 7, 7);
    step();
    chk("t4 len0", o_pkt_ctrl.pkt_len[0], 64);
    chk("t4 len4", o_pkt_ctrl.pkt_len[4], 65);
    chk("t4 len9", o_pkt_ctrl.pkt_len[9], 66);
    chk("t4 mty3", o_pkt_ctrl.mty[3], 0);
    chk("t4 mty8", o_pkt_ctrl.mty[8], 15);
    wait_done("t4", 7);
    // backpressure with an ignored start
    start_run(3'd5, 64, 64, 1'b0, 20, 20);
    step();
    step();
    i_rdy = 1'b0;
    i_start = 1'b1;
    i_cfg_len_min = 16'd100;
    step();
    i_start = 1'b0;
    repeat (4) step();
    i_rdy = 1'b1;
    wait_done("t5", 20);
    // stop mid 1500B packet
    start_run(3'd6, 1500, 1500, 1'b0, 0, 3);
    step();
    inj_err();
    step();
    step();
    for (int j = ptr + 11; j < nseg; j++) begin
      if (s_eop[j]) begin
        nseg = j + 1;
        break;
      end
    end
    chk("t6 model segs", nseg, 94);
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    wait_done("t6", 1);
    chk("t6 last ena", last_acc.ena, 12'h3FF);
    chk("t6 last eop", last_acc.eop, 12'h200);
    chk("t6 last err", last_acc.err, 12'h200);
    chk("t6 last mty", last_acc.mty[9], 4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
